nf10_axis_pkt_gen: RTL and testbench

- AXI4-Stream packet source for the loopback test. Drives the slave (transmit) stream of the 10G interface with numbered test frames.
- Stream format is 64-bit data, 8-bit tstrb, 128-bit tuser carrying NetFPGA length and port metadata.
- Software control lines start a run of N packets of a fixed length with a programmable inter-packet gap. Status counters report progress to the checker/register block.

---
 rtl/nf10_pkt_gen_pkg.sv | 28 ++
 rtl/nf10_pkt_gen_payload.sv | 62 ++++++
 rtl/nf10_axis_pkt_gen.sv | 164 ++++++++++++++++
 tb/tb_nf10_axis_pkt_gen.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/nf10_pkt_gen_pkg.sv
// Shared constants and helpers for the nf10 AXI4-Stream packet generator.
// FSM encodings, tuser field offsets, the last-beat strobe helper and LFSR taps.
package nf10_pkt_gen_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  localparam int unsigned LEN_LSB = 0;
  localparam int unsigned SRC_LSB = 16;
  localparam int unsigned DST_LSB = 24;

  localparam logic [31:0] LFSR_POLY = 32'h80200003;

  // Contiguous LSB strobes for a final beat holding rem bytes (0 means a full beat)
  function automatic logic [7:0] strb_from_rem(input logic [2:0] rem);
    logic [7:0] s;
    s = 8'hFF;
    if (rem != 3'd0) s = 8'hFF >> (4'd8 - {1'b0, rem});
    return s;
  endfunction

  // One Galois LFSR step
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
  endfunction

endpackage

// File: rtl/nf10_pkt_gen_payload.sv
// Beat-index counter and payload generator for nf10_axis_pkt_gen.
// Define PKT_GEN_LFSR_EN to fill beats 1..N-1 from a 32-bit Galois LFSR;
// otherwise every beat carries {seq, 16'h0000, beat index}.
module nf10_pkt_gen_payload
  import nf10_pkt_gen_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        load,
  input  logic        advance,
  input  logic [31:0] seq_next,
  input  logic [31:0] seq,
  output logic [15:0] beat_idx,
  output logic [63:0] data
);

  logic [15:0] beat_q, beat_d;

  // Beat index: restart on packet load, step on each accepted non-final beat
  always_comb begin
    beat_d = beat_q;
    if (load)         beat_d = '0;
    else if (advance) beat_d = beat_q + 16'd1;
  end

  // Beat index register
  always_ff @(posedge clk) begin
    if (!resetn) beat_q <= '0;
    else         beat_q <= beat_d;
  end

  assign beat_idx = beat_q;

`ifdef PKT_GEN_LFSR_EN
  logic [31:0] lfsr_q, lfsr_d;

  // LFSR seeded from the upcoming sequence number, two steps per accepted beat
  always_comb begin
    lfsr_d = lfsr_q;
    if (load)         lfsr_d = seq_next ^ 32'hFFFF_FFFF;
    else if (advance) lfsr_d = lfsr_step(lfsr_step(lfsr_q));
  end

  // LFSR register
  always_ff @(posedge clk) begin
    if (!resetn) lfsr_q <= '0;
    else         lfsr_q <= lfsr_d;
  end

  // Beat 0 keeps the sequence number visible to the checker
  always_comb begin
    if (beat_q == 16'd0) data = {seq, 16'h0000, beat_q};
    else                 data = {lfsr_q, lfsr_step(lfsr_q)};
  end
`else
  logic unused_seq_next;
  assign unused_seq_next = ^seq_next;

  assign data = {seq, 16'h0000, beat_q};
`endif

endmodule

// File: rtl/nf10_axis_pkt_gen.sv
// AXI4-Stream test-frame source: runs of numbered fixed-length packets with a
// programmable inter-packet gap. Optional macro PKT_GEN_LFSR_EN selects an
// LFSR payload in nf10_pkt_gen_payload.
module nf10_axis_pkt_gen
  import nf10_pkt_gen_pkg::*;
#(
  parameter int         C_M_AXIS_DATA_WIDTH  = 64,
  parameter int         C_M_AXIS_TUSER_WIDTH = 128,
  parameter logic [7:0] C_SRC_PORT           = 8'h01,
  parameter logic [7:0] C_DST_PORT           = 8'h01,
  parameter int         C_MIN_LEN            = 60,
  parameter int         C_MAX_LEN            = 1514
) (
  input  logic                              axi_aclk,
  input  logic                              axi_resetn,
  input  logic                              start,
  input  logic                              stop,
  input  logic [31:0]                       cfg_pkt_count,
  input  logic [15:0]                       cfg_pkt_len,
  input  logic [7:0]                        cfg_ifg,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic                              m_axis_tlast,
  output logic                              busy,
  output logic [31:0]                       pkts_sent,
  output logic [31:0]                       cur_seq
);

  logic [1:0]  state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [15:0] beats_q, beats_d;
  logic [7:0]  last_strb_q, last_strb_d;
  logic [31:0] count_q, count_d;
  logic [7:0]  ifg_q, ifg_d;
  logic [7:0]  gap_q, gap_d;
  logic [31:0] pkts_q, pkts_d;
  logic [31:0] seq_q, seq_d;

  logic [15:0] len_clamped;
  logic [15:0] beat_idx;
  logic [63:0] payload;
  logic        valid, last_beat, hs, load, advance;
  logic [C_M_AXIS_TUSER_WIDTH-1:0] tuser_w;

  assign valid     = (state_q == ST_SEND);
  assign last_beat = (beat_idx == beats_q - 16'd1);
  assign hs        = valid & m_axis_tready;
  assign advance   = hs & ~last_beat;

  // Requested length clamped to the legal frame range
  always_comb begin
    len_clamped = cfg_pkt_len;
    if (cfg_pkt_len < 16'(C_MIN_LEN))      len_clamped = 16'(C_MIN_LEN);
    else if (cfg_pkt_len > 16'(C_MAX_LEN)) len_clamped = 16'(C_MAX_LEN);
  end

  // Run control FSM, config latch and progress counters
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    beats_d     = beats_q;
    last_strb_d = last_strb_q;
    count_d     = count_q;
    ifg_d       = ifg_q;
    gap_d       = gap_q;
    pkts_d      = pkts_q;
    seq_d       = seq_q;
    load        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          len_d       = len_clamped;
          beats_d     = (len_clamped + 16'd7) >> 3;
          last_strb_d = strb_from_rem(len_clamped[2:0]);
          count_d     = cfg_pkt_count;
          ifg_d       = cfg_ifg;
          pkts_d      = '0;
          seq_d       = '0;
          load        = 1'b1;
          state_d     = ST_SEND;
        end
      end
      ST_SEND: begin
        if (hs && last_beat) begin
          pkts_d = pkts_q + 32'd1;
          seq_d  = seq_q + 32'd1;
          load   = 1'b1;
          if (stop || (count_q != '0 && pkts_q + 32'd1 == count_q)) begin
            state_d = ST_IDLE;
          end else if (ifg_q == '0) begin
            state_d = ST_SEND;
          end else begin
            state_d = ST_GAP;
            gap_d   = ifg_q - 8'd1;
          end
        end
      end
      ST_GAP: begin
        if (stop)              state_d = ST_IDLE;
        else if (gap_q == '0)  state_d = ST_SEND;
        else                   gap_d   = gap_q - 8'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and counter registers
  always_ff @(posedge axi_aclk) begin
    if (!axi_resetn) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      beats_q     <= '0;
      last_strb_q <= '0;
      count_q     <= '0;
      ifg_q       <= '0;
      gap_q       <= '0;
      pkts_q      <= '0;
      seq_q       <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      beats_q     <= beats_d;
      last_strb_q <= last_strb_d;
      count_q     <= count_d;
      ifg_q       <= ifg_d;
      gap_q       <= gap_d;
      pkts_q      <= pkts_d;
      seq_q       <= seq_d;
    end
  end

  nf10_pkt_gen_payload u_payload (
    .clk      (axi_aclk),
    .resetn   (axi_resetn),
    .load     (load),
    .advance  (advance),
    .seq_next (seq_d),
    .seq      (seq_q),
    .beat_idx (beat_idx),
    .data     (payload)
  );

  // tuser metadata: clamped length and port maps, remaining bits zero
  always_comb begin
    tuser_w                 = '0;
    tuser_w[LEN_LSB +: 16]  = len_q;
    tuser_w[SRC_LSB +: 8]   = C_SRC_PORT;
    tuser_w[DST_LSB +: 8]   = C_DST_PORT;
  end

  // Stream fields are zero whenever no beat is offered
  assign m_axis_tvalid = valid;
  assign m_axis_tdata  = valid ? payload : '0;
  assign m_axis_tstrb  = valid ? (last_beat ? last_strb_q : 8'hFF) : '0;
  assign m_axis_tlast  = valid & last_beat;
  assign m_axis_tuser  = valid ? tuser_w : '0;
  assign busy          = (state_q != ST_IDLE);
  assign pkts_sent     = pkts_q;
  assign cur_seq       = seq_q;

endmodule

// File: tb/tb_nf10_axis_pkt_gen.sv
// Self-checking bench for nf10_axis_pkt_gen (default build, counter payload).
module tb_nf10_axis_pkt_gen;

  logic          clk = 1'b0;
  logic          resetn;
  logic          start, stop;
  logic [31:0]   cfg_pkt_count;
  logic [15:0]   cfg_pkt_len;
  logic [7:0]    cfg_ifg;
  logic [63:0]   tdata;
  logic [7:0]    tstrb;
  logic [127:0]  tuser;
  logic          tvalid, tready, tlast, busy;
  logic [31:0]   pkts_sent, cur_seq;

  always #5 clk = ~clk;

  nf10_axis_pkt_gen dut (
    .axi_aclk      (clk),
    .axi_resetn    (resetn),
    .start         (start),
    .stop          (stop),
    .cfg_pkt_count (cfg_pkt_count),
    .cfg_pkt_len   (cfg_pkt_len),
    .cfg_ifg       (cfg_ifg),
    .m_axis_tdata  (tdata),
    .m_axis_tstrb  (tstrb),
    .m_axis_tuser  (tuser),
    .m_axis_tvalid (tvalid),
    .m_axis_tready (tready),
    .m_axis_tlast  (tlast),
    .busy          (busy),
    .pkts_sent     (pkts_sent),
    .cur_seq       (cur_seq)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [63:0]  data;
    logic [7:0]   strb;
    logic         last;
    logic [127:0] user;
  } beat_t;

  typedef struct {
    logic [15:0] len;
    logic [31:0] cnt;
    logic [7:0]  ifg;
    int unsigned pct;
    int unsigned exp_beats;
    logic [7:0]  exp_strb;
    logic [15:0] exp_ulen;
  } vec_t;

  beat_t       cap[$];
  int unsigned gaps[$];
  bit          in_gap, in_pkt, prev_stall;
  int unsigned gap_cnt;
  beat_t       prev;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    cap.delete();
    gaps.delete();
    in_gap = 0; in_pkt = 0; prev_stall = 0; gap_cnt = 0;
  endtask

  // Observe one cycle at the negedge (inputs already set), then advance a cycle
  task automatic cycle();
    beat_t b;
    b.data = tdata; b.strb = tstrb; b.last = tlast; b.user = tuser;
    if (in_pkt || prev_stall) chk("valid_held", tvalid, 1'b1);
    if (prev_stall && tvalid) begin
      chk("stall_data", b.data, prev.data);
      chk("stall_ctl", {b.user, b.strb, b.last}, {prev.user, prev.strb, prev.last});
    end
    if (in_gap) begin
      if (!tvalid) gap_cnt++;
      else begin gaps.push_back(gap_cnt); in_gap = 0; end
    end
    if (tvalid && tready) begin
      cap.push_back(b);
      in_pkt = !b.last;
      if (b.last) begin in_gap = 1; gap_cnt = 0; end
    end
    prev_stall = tvalid && !tready;
    prev = b;
    @(negedge clk);
  endtask

  task automatic start_run(input logic [15:0] len, input logic [31:0] cnt, input logic [7:0] ifg);
    clear_mon();
    cfg_pkt_len = len; cfg_pkt_count = cnt; cfg_ifg = ifg;
    start = 1'b1;
    chk("idle_before_start", tvalid, 1'b0);
    cycle();
    start = 1'b0;
    chk("tvalid_after_start", tvalid, 1'b1);
    chk("busy_after_start", busy, 1'b1);
  endtask

  task automatic drain(input int unsigned pct);
    int unsigned n = 0;
    while (busy && n < 20000) begin
      tready = ($urandom_range(0, 99) < pct);
      cycle();
      n++;
    end
    chk("busy_falls", busy, 1'b0);
  endtask

  // Reference: packet p, beat k of a clamped length-L frame
  task automatic verify(input logic [15:0] len, input int unsigned npk, input int unsigned ifg);
    int unsigned L, nb, idx;
    logic [31:0] pp;
    logic [15:0] kk;
    logic [7:0]  es;
    logic [63:0] ed;
    L  = (len < 60) ? 60 : (len > 1514) ? 1514 : len;
    nb = (L + 7) / 8;
    chk("beat_total", cap.size(), npk * nb);
    for (int unsigned p = 0; p < npk; p++) begin
      for (int unsigned k = 0; k < nb; k++) begin
        idx = p * nb + k;
        if (idx < cap.size()) begin
          pp = p; kk = k[15:0];
          ed = {pp, 16'h0000, kk};
          for (int i = 0; i < 8; i++) es[i] = (8 * k + i < L);
          chk("beat",
              {cap[idx].data, cap[idx].strb, 7'b0, cap[idx].last, cap[idx].user[31:0], 15'b0, |cap[idx].user[127:32]},
              {ed, es, 7'b0, (k == nb - 1), 8'h01, 8'h01, L[15:0], 16'b0});
        end
      end
    end
    chk("gap_count", gaps.size(), npk - 1);
    foreach (gaps[i]) chk("gap_len", gaps[i], ifg);
    chk("pkts_sent", pkts_sent, npk);
    chk("cur_seq", cur_seq, npk);
  endtask

  initial begin
    vec_t vt[6];
    int unsigned nobs, lasts, n;
    logic [15:0] rl;
    logic [31:0] rc;
    logic [7:0]  ri;
    int unsigned rp;

    vt[0] = '{16'd64,   32'd2, 8'd4, 100, 8,   8'hFF, 16'd64};
    vt[1] = '{16'd65,   32'd1, 8'd2, 100, 9,   8'h01, 16'd65};
    vt[2] = '{16'd70,   32'd1, 8'd0, 100, 9,   8'h3F, 16'd70};
    vt[3] = '{16'd128,  32'd3, 8'd1, 50,  16,  8'hFF, 16'd128};
    vt[4] = '{16'd20,   32'd1, 8'd0, 100, 8,   8'h0F, 16'd60};
    vt[5] = '{16'd4000, 32'd1, 8'd0, 70,  190, 8'h03, 16'd1514};

    resetn = 1'b0; start = 1'b0; stop = 1'b0; tready = 1'b1;
    cfg_pkt_count = '0; cfg_pkt_len = '0; cfg_ifg = '0;
    repeat (3) @(negedge clk);
    chk("rst_tvalid", tvalid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_pkts", pkts_sent, 32'd0);
    chk("rst_seq", cur_seq, 32'd0);
    chk("rst_stream", {tdata, tstrb, tlast}, '0);
    chk("rst_tuser", tuser, '0);
    resetn = 1'b1;
    @(negedge clk);

    // Table-driven runs
    for (int v = 0; v < 6; v++) begin
      tready = 1'b1;
      start_run(vt[v].len, vt[v].cnt, vt[v].ifg);
      drain(vt[v].pct);
      nobs = 0;
      foreach (cap[i]) begin
        if (nobs == 0 && cap[i].last) begin
          nobs = i + 1;
          chk("tbl_last_strb", cap[i].strb, vt[v].exp_strb);
        end
      end
      chk("tbl_beats", nobs, vt[v].exp_beats);
      if (cap.size() > 0) chk("tbl_user_len", cap[0].user[15:0], vt[v].exp_ulen);
      verify(vt[v].len, vt[v].cnt, vt[v].ifg);
    end

    // Randomized runs against the reference
    for (int r = 0; r < 8; r++) begin
      rl = 16'($urandom_range(1, 1700));
      rc = 32'($urandom_range(1, 3));
      ri = 8'($urandom_range(0, 6));
      rp = $urandom_range(30, 100);
      tready = 1'b1;
      start_run(rl, rc, ri);
      drain(rp);
      verify(rl, rc, ri);
    end

    // Continuous mode: ignored start while busy, stop on beat 3 of packet 3
    tready = 1'b1;
    start_run(16'd64, 32'd0, 8'd0);
    lasts = 0; n = 0;
    while (n < 200) begin
      if (n == 4) begin start = 1'b1; cfg_pkt_len = 16'd100; cfg_pkt_count = 32'd1; end
      else start = 1'b0;
      cycle();
      n++;
      lasts = 0;
      foreach (cap[i]) if (cap[i].last) lasts++;
      if (lasts == 3 && tvalid && tdata[15:0] == 16'd3) break;
    end
    start = 1'b0;
    chk("cont_reached_stop_point", lasts, 3);
    stop = 1'b1;
    drain(100);
    stop = 1'b0;
    verify(16'd64, 4, 0);

    // Reset mid-packet, then a fresh run restarts at sequence 0
    tready = 1'b1;
    start_run(16'd64, 32'd2, 8'd0);
    n = 0;
    while (n < 100 && !(tvalid && tdata[63:32] == 32'd1 && tdata[15:0] == 16'd5)) begin
      cycle();
      n++;
    end
    chk("pre_reset_beat", tdata[15:0], 16'd5);
    chk("pre_reset_pkts", pkts_sent, 32'd1);
    resetn = 1'b0;
    @(negedge clk);
    chk("midrst_tvalid", tvalid, 1'b0);
    chk("midrst_pkts", pkts_sent, 32'd0);
    chk("midrst_busy", busy, 1'b0);
    resetn = 1'b1;
    @(negedge clk);
    start_run(16'd64, 32'd1, 8'd0);
    drain(100);
    verify(16'd64, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
